sync_debounce_edge: RTL and testbench

SYNC_DEBOUNCE_EDGE -- requirements
Module: sync_debounce_edge

---
 rtl/sync_debounce_edge.sv | 87 ++++++++
 tb/tb_sync_debounce_edge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// rtl/sync_debounce_edge.sv - multi-channel synchronizer, debouncer and edge pulse generator
module sync_debounce_edge #(
   parameter int WIDTH          = 1,
   parameter int SYNC_STAGES    = 2,
   parameter int SAMPLE_CNT_MAX = 2500,
   parameter int PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_signal,
   output logic [WIDTH-1:0] sync_signal,
   output logic [WIDTH-1:0] debounced,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   localparam int SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
   localparam int PCW = ($clog2(PULSE_CNT_MAX + 1) > 1) ? $clog2(PULSE_CNT_MAX + 1) : 1;
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
   localparam logic [PCW-1:0] PULSE_LAST  = PCW'(PULSE_CNT_MAX - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [SCW-1:0]   sample_cnt_q, sample_cnt_d;
   logic             tick;
   logic [PCW-1:0]   stab_q [WIDTH];
   logic [PCW-1:0]   stab_d [WIDTH];
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [WIDTH-1:0] rise_q, fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= async_signal;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_signal = sync_q[SYNC_STAGES-1];

   // One sample tick per SAMPLE_CNT_MAX cycles, shared by every channel
   assign tick         = (sample_cnt_q == SAMPLE_LAST);
   assign sample_cnt_d = tick ? '0 : sample_cnt_q + SCW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sample_cnt_q <= '0;
      else        sample_cnt_q <= sample_cnt_d;
   end

   // The counter tracks consecutive mismatching ticks; it toggles the level
   // instead of reaching PULSE_CNT_MAX, so it can never wrap.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < WIDTH; i++) begin
         stab_d[i] = stab_q[i];
         if (tick) begin
            if (sync_signal[i] == deb_q[i]) begin
               stab_d[i] = '0;
            end else if (stab_q[i] == PULSE_LAST) begin
               stab_d[i] = '0;
               deb_d[i]  = ~deb_q[i];
            end else begin
               stab_d[i] = stab_q[i] + PCW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) stab_q[i] <= '0;
         deb_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) stab_q[i] <= stab_d[i];
         deb_q  <= deb_d;
         rise_q <= deb_d & ~deb_q;
         fall_q <= ~deb_d & deb_q;
      end
   end

   assign debounced  = deb_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb/tb_sync_debounce_edge.sv - table, directed and random checks of sync_debounce_edge
module tb_sync_debounce_edge;
   localparam int W  = 2;
   localparam int SS = 2;
   localparam int SC = 4;
   localparam int PC = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] async_a = '0;
   logic [W-1:0] sync_a, deb_a, rise_a, fall_a;
   logic         async_b = 1'b0;
   logic         sync_b, deb_b, rise_b, fall_b;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   sync_debounce_edge #(.WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SC), .PULSE_CNT_MAX(PC)) dut_a (
      .clk(clk), .rst_n(rst_n), .async_signal(async_a), .sync_signal(sync_a),
      .debounced(deb_a), .rise_pulse(rise_a), .fall_pulse(fall_a));

   sync_debounce_edge #(.WIDTH(1), .SYNC_STAGES(3), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .async_signal(async_b), .sync_signal(sync_b),
      .debounced(deb_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

   // Reference: sync is the input as sampled SS edges ago; a level flips after PC
   // consecutive ticks (every SC-th cycle since reset) that see a differing sync value.
   logic [W-1:0] hist[$];
   int unsigned  cyc;
   int           streak[W];
   logic [W-1:0] m_deb, m_rise, m_fall, m_s;

   function automatic logic [W-1:0] m_sync();
      return (hist.size() >= SS) ? hist[hist.size()-SS] : '0;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         hist.delete();
         cyc = 0;
         m_deb = '0; m_rise = '0; m_fall = '0;
         for (int i = 0; i < W; i++) streak[i] = 0;
      end else begin
         m_s = m_sync();
         m_rise = '0; m_fall = '0;
         if (cyc % SC == SC - 1) begin
            for (int i = 0; i < W; i++) begin
               if (m_s[i] == m_deb[i]) streak[i] = 0;
               else begin
                  streak[i] = streak[i] + 1;
                  if (streak[i] == PC) begin
                     streak[i] = 0;
                     m_deb[i] = ~m_deb[i];
                     if (m_deb[i]) m_rise[i] = 1'b1;
                     else          m_fall[i] = 1'b1;
                  end
               end
            end
         end
         hist.push_back(async_a);
         if (hist.size() > SS) void'(hist.pop_front());
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      chk("model_sync", 32'(sync_a), 32'(m_sync()));
      chk("model_deb", 32'(deb_a), 32'(m_deb));
      chk("model_rise", 32'(rise_a), 32'(m_rise));
      chk("model_fall", 32'(fall_a), 32'(m_fall));
      chk("rise_fall_excl", 32'(rise_a & fall_a), 32'(0));
   endtask

   typedef struct {
      logic [W-1:0] a;
      int           cycles;
      logic [W-1:0] deb;
      int           r0, r1, f0, f1, swap;
   } vec_t;

   vec_t tbl[7];
   int   nr0, nr1, nf0, nf1, nsw, k, len;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{a: 2'b00, cycles: 100, deb: 2'b00, r0: 0, r1: 0, f0: 0, f1: 0, swap: 0};
      tbl[1] = '{a: 2'b10, cycles: 6,   deb: 2'b00, r0: 0, r1: 0, f0: 0, f1: 0, swap: 0};
      tbl[2] = '{a: 2'b00, cycles: 30,  deb: 2'b00, r0: 0, r1: 0, f0: 0, f1: 0, swap: 0};
      tbl[3] = '{a: 2'b01, cycles: 20,  deb: 2'b01, r0: 1, r1: 0, f0: 0, f1: 0, swap: 0};
      tbl[4] = '{a: 2'b10, cycles: 20,  deb: 2'b10, r0: 0, r1: 1, f0: 1, f1: 0, swap: 1};
      tbl[5] = '{a: 2'b11, cycles: 20,  deb: 2'b11, r0: 1, r1: 0, f0: 0, f1: 0, swap: 0};
      tbl[6] = '{a: 2'b00, cycles: 20,  deb: 2'b00, r0: 0, r1: 0, f0: 1, f1: 1, swap: 0};

      repeat (2) @(negedge clk);
      chk("reset_outputs_a", 32'({sync_a, deb_a, rise_a, fall_a}), 32'(0));
      chk("reset_outputs_b", 32'({sync_b, deb_b, rise_b, fall_b}), 32'(0));
      rst_n = 1'b1;

      // Three-stage chain, tick every cycle
      async_b = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         cmp_all();
         chk($sformatf("b_sync_c%0d", c), 32'(sync_b), 32'(c >= 3));
         chk($sformatf("b_rise_c%0d", c), 32'(rise_b), 32'(c == 6));
      end
      chk("b_deb_final", 32'(deb_b), 32'(1));

      for (int r = 0; r < 7; r++) begin
         async_a = tbl[r].a;
         nr0 = 0; nr1 = 0; nf0 = 0; nf1 = 0; nsw = 0;
         repeat (tbl[r].cycles) begin
            @(negedge clk);
            cmp_all();
            nr0 += int'(rise_a[0]); nr1 += int'(rise_a[1]);
            nf0 += int'(fall_a[0]); nf1 += int'(fall_a[1]);
            if (fall_a[0] && rise_a[1]) nsw++;
         end
         chk($sformatf("row%0d_deb", r), 32'(deb_a), 32'(tbl[r].deb));
         chk($sformatf("row%0d_rise0", r), 32'(nr0), 32'(tbl[r].r0));
         chk($sformatf("row%0d_rise1", r), 32'(nr1), 32'(tbl[r].r1));
         chk($sformatf("row%0d_fall0", r), 32'(nf0), 32'(tbl[r].f0));
         chk($sformatf("row%0d_fall1", r), 32'(nf1), 32'(tbl[r].f1));
         chk($sformatf("row%0d_same_cycle", r), 32'(nsw), 32'(tbl[r].swap));
      end

      // Single step on channel 0: sync latency, debounce bound, single pulse
      async_a = 2'b01;
      @(negedge clk); cmp_all();
      chk("step_sync_1cyc", 32'(sync_a[0]), 32'(0));
      @(negedge clk); cmp_all();
      chk("step_sync_2cyc", 32'(sync_a[0]), 32'(1));
      k = 2;
      while (deb_a[0] !== 1'b1 && k < 20) begin
         @(negedge clk); cmp_all();
         k++;
      end
      chk("step_latency_le15", 32'(k <= 15), 32'(1));
      chk("step_rise_first", 32'(rise_a[0]), 32'(1));
      @(negedge clk); cmp_all();
      chk("step_rise_once", 32'(rise_a[0]), 32'(0));
      chk("step_ch1_quiet", 32'({sync_a[1], deb_a[1], rise_a[1], fall_a[1]}), 32'(0));

      // Asynchronous reset, then mid-count reset discards progress
      rst_n = 1'b0;
      #1;
      chk("async_reset_a", 32'({sync_a, deb_a, rise_a, fall_a}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk); cmp_all();
         chk("midcount_no_rise", 32'(rise_a[0]), 32'(0));
      end
      rst_n = 1'b0;
      #1;
      chk("midcount_reset_zero", 32'({sync_a, deb_a, rise_a, fall_a}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk); cmp_all();
         chk($sformatf("after_reset_rise_c%0d", c), 32'(rise_a[0]), 32'(c == 12));
      end

      repeat (60) begin
         async_a = W'($urandom);
         len = int'($urandom_range(1, 40));
         repeat (len) begin
            @(negedge clk); cmp_all();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
